// File: rtl/addr_unit.sv
// addr_unit: fetch/decode/address sequencer for a tiny load/store core.
// Optional: ADDR_UNIT_OVF_EN enables the sticky address-carry flag on ovf.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   hold             stall, freezes all state
//   mem_rdata [DW]   sync RAM read data (one cycle after address)
//   regb      [AW]   base register for indexed addressing
//   cond             branch condition, sampled in DECODE
//   mem_addr  [AW]   RAM address (pc in FETCH/LOAD_IR/DECODE, rdir in MEM/WB)
//   mem_we           RAM write enable (store in MEM)
//   ir        [DW]   instruction register
//   pc        [AW]   program counter
//   rdir      [AW]   effective data address register
//   load_valid       one-cycle pulse in WB: mem_rdata holds load data
//   state     [3]    FETCH=0 LOAD_IR=1 DECODE=2 MEM=3 WB=4
//   ovf              sticky address-overflow flag (0 unless ADDR_UNIT_OVF_EN)
module addr_unit #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic [DW-1:0] mem_rdata,
  input  logic [AW-1:0] regb,
  input  logic          cond,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] rdir,
  output logic          load_valid,
  output logic [2:0]    state,
  output logic          ovf
);

  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_LOAD_IR = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] rdir_q, rdir_d;

  logic [1:0]    op;
  logic [AW-1:0] offs;
  logic [AW-1:0] ea;
  logic          is_mem_op;

  assign op        = ir_q[DW-1:DW-2];
  assign offs      = ir_q[AW-1:0];
  assign is_mem_op = (op == OP_LOAD) || (op == OP_STORE);

`ifdef ADDR_UNIT_OVF_EN
  logic [AW:0] ea_w;
  logic        ovf_q, ovf_d;

  assign ea_w = {1'b0, regb} + {1'b0, offs};
  assign ea   = ea_w[AW-1:0];

  // Carry only counts for real memory accesses, and never while stalled.
  always_comb begin
    ovf_d = ovf_q;
    if (!hold && state_q == S_DECODE && is_mem_op && ea_w[AW])
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ea  = regb + offs;
  assign ovf = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_LOAD_IR;
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE:  state_d = is_mem_op ? S_MEM : S_FETCH;
      S_MEM:     state_d = (op == OP_STORE) ? S_FETCH : S_WB;
      S_WB:      state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
    // Stall freezes legal states; stray encodings still recover.
    if (hold && state_q <= S_WB)
      state_d = state_q;
  end

  // Output logic
  always_comb begin
    mem_addr   = pc_q;
    mem_we     = 1'b0;
    load_valid = 1'b0;
    case (state_q)
      S_MEM: begin
        mem_addr = rdir_q;
        mem_we   = !hold && (op == OP_STORE);
      end
      S_WB: begin
        mem_addr   = rdir_q;
        load_valid = !hold;
      end
      default: mem_addr = pc_q;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    rdir_d = rdir_q;
    if (!hold) begin
      case (state_q)
        S_LOAD_IR: begin
          ir_d = mem_rdata;
          pc_d = pc_q + 1'b1;
        end
        S_DECODE: begin
          rdir_d = ea;
          if (op == OP_BRANCH && cond)
            pc_d = offs;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RST_PC;
      ir_q   <= '0;
      rdir_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      rdir_q <= rdir_d;
    end
  end

  assign state = state_q;
  assign pc    = pc_q;
  assign ir    = ir_q;
  assign rdir  = rdir_q;

endmodule

// File: tb/tb_addr_unit.sv
// tb_addr_unit: directed vectors for addr_unit with a memory-event
// scoreboard (load_valid / mem_we pulses) plus per-cycle state checks.
module tb_addr_unit;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [15:0] mem_rdata;
  logic [7:0]  regb;
  logic        cond;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic [7:0]  rdir;
  logic        load_valid;
  logic [2:0]  state;
  logic        ovf;

`ifdef ADDR_UNIT_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       is_store;
    logic [7:0] addr;
  } ev_t;

  ev_t sb[$];

  logic [15:0] ram [256];

  addr_unit #(.AW(8), .DW(16), .RESET_PC(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hold(hold),
    .mem_rdata(mem_rdata),
    .regb(regb),
    .cond(cond),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .ir(ir),
    .pc(pc),
    .rdir(rdir),
    .load_valid(load_valid),
    .state(state),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    mem_rdata <= ram[mem_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every memory event must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (load_valid || mem_we)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL mem_event: unexpected lv=%0b we=%0b addr=%h",
                 load_valid, mem_we, mem_addr);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (mem_we !== e.is_store || load_valid === mem_we ||
            mem_addr !== e.addr) begin
          bad++;
          $display("FAIL mem_event: got we=%0b lv=%0b addr=%h want we=%0b addr=%h",
                   mem_we, load_valid, mem_addr, e.is_store, e.addr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic st, input logic [7:0] a);
    ev_t e;
    e.is_store = st;
    e.addr     = a;
    sb.push_back(e);
  endtask

  // Called at posedge+1: reset pulse, release well before next edge.
  task automatic start(input logic [15:0] instr, input logic [7:0] rb,
                       input logic c);
    ram[0] = instr;
    regb   = rb;
    cond   = c;
    hold   = 1'b0;
    rst_n  = 1'b0;
    #2;
    rst_n  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    regb  = '0;
    cond  = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_ir", 32'(ir), 32'h0000);
    chk("rst_rdir", 32'(rdir), 32'h00);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_we_lv", 32'({mem_we, load_valid}), 32'd0);
    tick();

    // ALU: 3-cycle sequence
    start(16'hC000, 8'h00, 1'b0);
    tick();
    chk("alu_s1", 32'(state), 32'd1);
    chk("alu_pc0", 32'(pc), 32'h00);
    tick();
    chk("alu_s2", 32'(state), 32'd2);
    chk("alu_ir", 32'(ir), 32'hC000);
    chk("alu_pc1", 32'(pc), 32'h01);
    tick();
    chk("alu_s0", 32'(state), 32'd0);
    chk("alu_addr", 32'(mem_addr), 32'h01);

    // Load: rdir = 0x10 + 0x05
    push(1'b0, 8'h15);
    start(16'h0005, 8'h10, 1'b0);
    tick(); tick(); tick();
    chk("ld_s3", 32'(state), 32'd3);
    chk("ld_rdir", 32'(rdir), 32'h15);
    chk("ld_addr_mem", 32'(mem_addr), 32'h15);
    tick();
    chk("ld_s4", 32'(state), 32'd4);
    chk("ld_addr_wb", 32'(mem_addr), 32'h15);
    chk("ld_lv", 32'(load_valid), 32'd1);
    tick();
    chk("ld_s0", 32'(state), 32'd0);
    chk("ld_next_pc", 32'(mem_addr), 32'h01);
    chk("ld_lv_off", 32'(load_valid), 32'd0);

    // Store: addr 0x02 + 0x03
    push(1'b1, 8'h05);
    start(16'h4003, 8'h02, 1'b0);
    tick(); tick(); tick();
    chk("st_s3", 32'(state), 32'd3);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_addr", 32'(mem_addr), 32'h05);
    tick();
    chk("st_s0", 32'(state), 32'd0);
    chk("st_we_off", 32'(mem_we), 32'd0);

    // Branch taken / not taken
    start(16'h8020, 8'h00, 1'b1);
    tick(); tick(); tick();
    chk("br_t_state", 32'(state), 32'd0);
    chk("br_t_addr", 32'(mem_addr), 32'h20);
    start(16'h8020, 8'h00, 1'b0);
    tick(); tick(); tick();
    chk("br_nt_addr", 32'(mem_addr), 32'h01);

    // Hold in LOAD_IR freezes pc and ir
    start(16'hC000, 8'h00, 1'b0);
    tick();
    hold = 1'b1;
    tick();
    chk("hold_li_state", 32'(state), 32'd1);
    chk("hold_li_pc", 32'(pc), 32'h00);
    chk("hold_li_ir", 32'(ir), 32'h0000);
    hold = 1'b0;
    tick();
    chk("hold_li_ir2", 32'(ir), 32'hC000);
    chk("hold_li_pc2", 32'(pc), 32'h01);

    // Overflowing load, stalled 3 cycles in MEM
    push(1'b0, 8'h10);
    start(16'h0020, 8'hF0, 1'b0);
    tick(); tick(); tick();
    chk("ovf_rdir", 32'(rdir), 32'h10);
    chk("ovf_flag", 32'(ovf), 32'(OVF_EXP));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_mem_state", 32'(state), 32'd3);
      chk("hold_mem_we", 32'(mem_we), 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("ovf_wb", 32'(state), 32'd4);
    tick();
    chk("ovf_fetch", 32'(state), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'(OVF_EXP));

    // Store stalled in MEM: write enable withheld until release
    push(1'b1, 8'h05);
    start(16'h4003, 8'h02, 1'b0);
    tick(); tick(); tick();
    hold = 1'b1;
    #1;
    chk("hold_st_we", 32'(mem_we), 32'd0);
    tick();
    chk("hold_st_state", 32'(state), 32'd3);
    hold = 1'b0;
    #1;
    chk("hold_st_we_rel", 32'(mem_we), 32'd1);
    tick();
    chk("hold_st_done", 32'(state), 32'd0);

    // PC wrap at 0xFF, then async reset in DECODE
    ram[8'hFF] = 16'hC000;
    start(16'h80FF, 8'h00, 1'b1);
    tick(); tick(); tick();
    chk("wrap_fetch", 32'(mem_addr), 32'hFF);
    tick(); tick();
    chk("wrap_state", 32'(state), 32'd2);
    chk("wrap_pc", 32'(pc), 32'h00);
    chk("wrap_ir", 32'(ir), 32'hC000);
    chk("wrap_rdir_pre", 32'(rdir), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_pc", 32'(pc), 32'h00);
    chk("async_ir", 32'(ir), 32'h0000);
    chk("async_rdir", 32'(rdir), 32'h00);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_s1", 32'(state), 32'd1);
    chk("post_rst_pc", 32'(pc), 32'h00);

    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_unit.md
ADDR_UNIT -- requirements
Module: addr_unit

Interface
REQ-001 The block SHALL provide parameter AW, default 8, memory address width in bits.
REQ-002 The block SHALL provide parameter DW, default 16, instruction width in bits; DW >= AW+2 is required.
REQ-003 The block SHALL provide parameter RESET_PC, default 0, PC value after reset.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port hold  input  1  stall; freezes all state while 1.
REQ-007 Port mem_rdata  input  DW  synchronous RAM read data, valid one cycle after address presented.
REQ-008 Port regb  input  AW  base register value for indexed addressing.
REQ-009 Port cond  input  1  branch condition, sampled in DECODE.
REQ-010 Port mem_addr  output  AW  RAM address.
REQ-011 Port mem_we  output  1  RAM write enable.
REQ-012 Port ir  output  DW  instruction register.
REQ-013 Port pc  output  AW  program counter.
REQ-014 Port rdir  output  AW  effective data address register.
REQ-015 Port load_valid  output  1  one-cycle pulse: mem_rdata holds load data.
REQ-016 Port state  output  3  FSM state: FETCH=0, LOAD_IR=1, DECODE=2, MEM=3, WB=4.
REQ-017 Port ovf  output  1  sticky address-overflow flag.

Function
REQ-018 Opcode SHALL be ir[DW-1:DW-2]: 00 load, 01 store, 10 branch, 11 ALU; offset/target SHALL be ir[AW-1:0].
REQ-019 FETCH: mem_addr=pc; next LOAD_IR.
REQ-020 LOAD_IR: ir<=mem_rdata, pc<=pc+1 modulo 2^AW; next DECODE.
REQ-021 DECODE: rdir<=(regb+ir[AW-1:0]) modulo 2^AW for every opcode; load/store -> MEM; branch with cond=1 -> pc<=ir[AW-1:0], FETCH; branch with cond=0 or ALU -> FETCH.
REQ-022 MEM: mem_addr=rdir; mem_we=1 only for store; store -> FETCH, load -> WB.
REQ-023 WB: load_valid=1 for exactly this cycle; mem_addr=rdir; next FETCH.
REQ-024 mem_addr SHALL be pc in FETCH, LOAD_IR and DECODE, rdir in MEM and WB; combinational from registered state.
REQ-025 Instruction latency SHALL be 3 cycles (ALU, branch), 4 (store), 5 (load), with hold=0.
REQ-026 While hold=1: state, pc, ir, rdir, ovf SHALL not change; mem_we and load_valid SHALL be 0; mem_addr follows REQ-024.
REQ-027 pc=2^AW-1 in LOAD_IR SHALL wrap to 0; branch in DECODE takes priority over nothing else (pc increment already done in LOAD_IR).
REQ-028 Unused state encodings 5-7 SHALL return to FETCH on the next edge.

Reset
REQ-029 rst_n=0 SHALL immediately force pc=RESET_PC, ir=0, rdir=0, ovf=0, state=FETCH, mem_we=0, load_valid=0, regardless of clk or hold.
REQ-030 Reset asserted mid-instruction SHALL abandon it; first edge after release performs FETCH from RESET_PC.

Configuration
REQ-031 Macro ADDR_UNIT_OVF_EN defined: ovf SHALL set in DECODE (load/store only, hold=0) when regb+ir[AW-1:0] carries out of AW bits, and stay set until reset.
REQ-032 Macro ADDR_UNIT_OVF_EN undefined: ovf port SHALL exist and be tied to 0; no carry logic.

Verification
REQ-033 Reset release, RAM[0]=16'hC000 (ALU) -> state 0,1,2,0; pc 0->1; ir=16'hC000 after LOAD_IR edge.
REQ-034 RAM[0]=16'h0005 (load), regb=8'h10 -> rdir=8'h15; mem_addr=8'h15 in MEM and WB; load_valid high one cycle in WB; next FETCH at pc=1.
REQ-035 RAM[0]=16'h4003 (store), regb=8'h02 -> mem_we=1 for exactly one cycle with mem_addr=8'h05; no load_valid.
REQ-036 RAM[0]=16'h8020 (branch), cond=1 -> next FETCH mem_addr=8'h20; cond=0 -> next FETCH mem_addr=8'h01.
REQ-037 Load with regb=8'hF0, offset 8'h20 -> rdir=8'h10; ovf=1 with ADDR_UNIT_OVF_EN, ovf=0 without; hold=1 for 3 cycles in MEM -> mem_we=0, state stays 3.
REQ-038 pc=8'hFF fetch then rst_n pulsed low in DECODE -> pc=0 after LOAD_IR wrap; reset forces state=0, pc=RESET_PC asynchronously.
